lmsm_sequencer: RTL
===================

# lmsm_sequencer

Multi-cycle sequencer for the load-multiple (LM) and store-multiple (SM) instructions of the 16-bit pipelined core. It is the initiator side of the data-memory port: it drives read address, write address, write data and active-low write strobe. On the register-file side it reads source registers for SM and writes destination registers for LM. It holds `busy` high while transferring so the pipeline stalls, then pulses `done`.

## Interface
- No parameters. Word width 16, register index 3 bits, mask 8 bits are fixed.
- `clk  in  1` – clock; all state changes on rising edge.
- `reset  in  1` – reset, synchronous, active-low.
- `start  in  1` – begin an LM/SM; sampled only in IDLE.
- `is_store  in  1` – 1 = SM, 0 = LM; latched with `start`.
- `base_addr  in  16` – first memory address; latched with `start`.
- `reg_mask  in  8` – bit i set = transfer Ri; latched with `start`.
- `base_sel  in  3` – base register index; used only with `LMSM_BASE_WB_EN`.
- `busy  out  1` – high in XFER.
- `done  out  1` – one-cycle pulse in DONE.
- `mem_read_add  out  16` – data-memory read address; memory returns data combinationally.
- `mem_rdata  in  16` – data-memory read data.
- `mem_write_add  out  16` – data-memory write address.
- `mem_wdata  out  16` – data-memory write data.
- `mem_write_n  out  1` – active-low write strobe; memory writes on the rising edge while it is 0.
- `rf_read_sel  out  3` – register-file async read index.
- `rf_read_data  in  16` – register-file read data.
- `rf_write_sel  out  3` – register-file write index.
- `rf_write_data  out  16` – register-file write data.
- `rf_write_en  out  1` – register-file write enable, active-high.

## Operation
- States: IDLE, XFER, DONE.
- Internal registers: `mask_r[7:0]`, `ptr[15:0]`, `store_r`, `base_sel_r`.
- IDLE:
  - When `start`=1, latch mask, `base_addr` to `ptr`, `is_store` and `base_sel`.
  - If `reg_mask`≠0, go to XFER; if `reg_mask`=0, go to DONE.
  - `start`=0 keeps the block in IDLE.
- XFER, every cycle:
  - Let i be the lowest set bit of `mask_r`.
  - LM: `mem_read_add`=`ptr`, `rf_write_sel`=i, `rf_write_data`=`mem_rdata`, `rf_write_en`=1.
  - SM: `rf_read_sel`=i, `mem_write_add`=`ptr`, `mem_wdata`=`rf_read_data`, `mem_write_n`=0.
  - At the clock edge, clear bit i and set `ptr`←`ptr`+1, modulo 2^16 (0xFFFF wraps to 0x0000).
  - Go to DONE when the cleared mask becomes 0; otherwise stay in XFER.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE. `start` in DONE or XFER is ignored and is not queued.
- Idle output values, held in IDLE and DONE and forced while reset is active:
  - `busy`=0, `done`=0 (except in DONE).
  - `mem_write_n`=1, `rf_write_en`=0 (except in DONE with the write-back feature).
  - All address, select and data outputs 0.
- Reset (`reset`=0):
  - At the edge: state←IDLE, `mask_r`←0, `ptr`←0.
  - During the reset cycle, `mem_write_n` and `rf_write_en` are gated inactive combinationally. Reset mid-XFER therefore completes no further transfer and produces no `done`.

## Timing
- Start sampled at edge 0. With n = popcount(mask), n ≥ 1:
  - Transfers occupy cycles 1..n.
  - `done` is high in cycle n+1.
  - IDLE in cycle n+2, where a new `start` is accepted.
- Mask 0: `done` is high in cycle 1; `busy` is never asserted.
- Each transfer is a single cycle. LM relies on a combinational memory read; SM relies on a combinational register-file read. The write commits at the end of the transfer cycle.
- Transfer order is ascending register index at ascending addresses.

## Configuration
- `LMSM_BASE_WB_EN` defined:
  - In DONE, `rf_write_en`=1, `rf_write_sel`=`base_sel_r`, `rf_write_data`=`ptr` (equal to base + n, modulo 2^16).
  - This applies to both LM and SM, including mask 0 (writes back base unchanged).
- Not defined: `base_sel` is ignored and `rf_write_en`=0 in DONE.

## Test plan
- **LM:** mask=0x60, base=0x0014, mem[0x14]=0x0001, mem[0x15]=0x0002. Required: R5=0x0001, R6=0x0002; `busy` high for 2 cycles; `done` in cycle 3.
- **SM:** mask=0x81, base=0x0030, R0=0xAAAA, R7=0x5555. Required: mem[0x30]=0xAAAA, mem[0x31]=0x5555; no other memory writes; `mem_write_n`=0 only in cycles 1-2.
- **Empty mask:** mask=0x00. Required: no memory or register writes; `busy` stays 0; `done` in cycle 1; next `start` accepted in cycle 2.
- **Wrap:** LM, mask=0xFF, base=0xFFFE. Required: read addresses 0xFFFE, 0xFFFF, 0x0000…0x0005 across 8 cycles; R0..R7 loaded in that order; `done` in cycle 9.
- **Reset mid-op:** SM, mask=0x0F, `reset`=0 in cycle 3. Required: only R0 and R1 are stored; no write in cycle 3; the block is IDLE with all outputs at idle values; no `done`.
- **Ignored start / write-back:** `start` pulsed during XFER is ignored, with exactly one `done`. With `LMSM_BASE_WB_EN`, LM mask=0x06, base=0x0020, base_sel=3: required R3=0x0022 written in the DONE cycle.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - LM/SM multi-cycle sequencer; LMSM_BASE_WB_EN adds base register write-back in DONE
module lmsm_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [15:0] base_addr,
  input  logic [7:0]  reg_mask,
  input  logic [2:0]  base_sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_read_add,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_write_add,
  output logic [15:0] mem_wdata,
  output logic        mem_write_n,
  output logic [2:0]  rf_read_sel,
  input  logic [15:0] rf_read_data,
  output logic [2:0]  rf_write_sel,
  output logic [15:0] rf_write_data,
  output logic        rf_write_en
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [7:0]  mask_r;
  logic [15:0] ptr;
  logic        store_r;
  logic [2:0]  idx;
  logic [7:0]  mask_next;

`ifdef LMSM_BASE_WB_EN
  logic [2:0]  base_sel_r;

  // base register index is captured with start and written back in DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      base_sel_r <= 3'd0;
    end else if (state == ST_IDLE && start) begin
      base_sel_r <= base_sel;
    end
  end
`else
  logic unused_base_sel;
  assign unused_base_sel = ^base_sel;
`endif

  // index of the lowest pending register; the highest-priority hit is written last
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_r[i]) idx = 3'(i);
    end
  end

  // clearing the lowest set bit matches the register chosen by idx
  assign mask_next = mask_r & (mask_r - 8'd1);

  // control state, pending mask and address pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      mask_r  <= 8'd0;
      ptr     <= 16'd0;
      store_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_r  <= reg_mask;
            ptr     <= base_addr;
            store_r <= is_store;
            state   <= (reg_mask == 8'd0) ? ST_DONE : ST_XFER;
          end
        end
        ST_XFER: begin
          mask_r <= mask_next;
          ptr    <= ptr + 16'd1;
          if (mask_next == 8'd0) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // port outputs; everything returns to idle values while reset is held low
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    mem_read_add  = 16'd0;
    mem_write_add = 16'd0;
    mem_wdata     = 16'd0;
    mem_write_n   = 1'b1;
    rf_read_sel   = 3'd0;
    rf_write_sel  = 3'd0;
    rf_write_data = 16'd0;
    rf_write_en   = 1'b0;
    if (reset) begin
      case (state)
        ST_XFER: begin
          busy = 1'b1;
          if (store_r) begin
            rf_read_sel   = idx;
            mem_write_add = ptr;
            mem_wdata     = rf_read_data;
            mem_write_n   = 1'b0;
          end else begin
            mem_read_add  = ptr;
            rf_write_sel  = idx;
            rf_write_data = mem_rdata;
            rf_write_en   = 1'b1;
          end
        end
        ST_DONE: begin
          done = 1'b1;
`ifdef LMSM_BASE_WB_EN
          rf_write_en   = 1'b1;
          rf_write_sel  = base_sel_r;
          rf_write_data = ptr;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
